// File: rtl/bnn_stream_pkg.sv
// Shared state encoding and sizing helpers for the BNN feature streamer.
package bnn_stream_pkg;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2,
        ST_DROP   = 2'd3
    } stream_state_e;

    function automatic int pred_bits(input int class_cnt);
        return (class_cnt > 1) ? $clog2(class_cnt) : 1;
    endfunction

    // Feature index width; a single-feature sample still needs a 1-bit index.
    function automatic int idx_bits(input int feat_cnt);
        return (feat_cnt > 1) ? $clog2(feat_cnt) : 1;
    endfunction

endpackage

// File: rtl/bnn_feature_streamer_if.sv
// Feature stream, classifier bus and result stream of the BNN feature streamer.
// BNN_STREAMER_STATS_EN adds the sample_cnt/err_cnt statistics outputs.
interface bnn_feature_streamer_if #(
    parameter int FEAT_CNT  = 12,
    parameter int FEAT_BITS = 4,
    parameter int CLASS_CNT = 6
);
    import bnn_stream_pkg::*;

    localparam int PRED_BITS = pred_bits(CLASS_CNT);

    logic                          s_valid;
    logic                          s_ready;
    logic [FEAT_BITS-1:0]          s_data;
    logic                          s_last;
    logic [FEAT_CNT*FEAT_BITS-1:0] feat_bus;
    logic [PRED_BITS-1:0]          pred_in;
    logic                          m_valid;
    logic                          m_ready;
    logic [PRED_BITS-1:0]          m_pred;
    logic                          frame_err;
`ifdef BNN_STREAMER_STATS_EN
    logic [31:0]                   sample_cnt;
    logic [15:0]                   err_cnt;

    modport slave (
        input  s_valid, s_data, s_last, pred_in, m_ready,
        output s_ready, feat_bus, m_valid, m_pred, frame_err, sample_cnt, err_cnt
    );

    modport master (
        output s_valid, s_data, s_last, pred_in, m_ready,
        input  s_ready, feat_bus, m_valid, m_pred, frame_err, sample_cnt, err_cnt
    );
`else
    modport slave (
        input  s_valid, s_data, s_last, pred_in, m_ready,
        output s_ready, feat_bus, m_valid, m_pred, frame_err
    );

    modport master (
        output s_valid, s_data, s_last, pred_in, m_ready,
        input  s_ready, feat_bus, m_valid, m_pred, frame_err
    );
`endif

endinterface

// File: rtl/bnn_settle_timer.sv
// Loadable down-counter that flags when the classifier settle window has elapsed.
module bnn_settle_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_done
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/bnn_feature_streamer.sv
// Serial-to-parallel feature loader and prediction capture for combinational BNN classifiers.
// BNN_STREAMER_STATS_EN enables the handshake and framing-error counters.
module bnn_feature_streamer #(
    parameter int FEAT_CNT      = 12,
    parameter int FEAT_BITS     = 4,
    parameter int CLASS_CNT     = 6,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bnn_feature_streamer_if.slave bus
);
    import bnn_stream_pkg::*;

    localparam int PRED_BITS = pred_bits(CLASS_CNT);
    localparam int IDX_BITS  = idx_bits(FEAT_CNT);
    localparam int CNT_W     = $clog2(SETTLE_CYCLES + 1);
    localparam logic [IDX_BITS-1:0] LAST_IDX    = IDX_BITS'(FEAT_CNT - 1);
    localparam logic [CNT_W-1:0]    SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    stream_state_e                 r_state;
    logic [IDX_BITS-1:0]           r_idx;
    logic [FEAT_CNT*FEAT_BITS-1:0] r_feat_bus;
    logic                          r_s_ready;
    logic                          r_m_valid;
    logic [PRED_BITS-1:0]          r_m_pred;
    logic                          r_frame_err;

    logic w_accept;
    logic w_at_last;
    logic w_load_beat;
    logic w_frame_err;
    logic w_handshake;
    logic w_timer_load;
    logic w_timer_en;
    logic w_timer_done;

    assign w_accept     = bus.s_valid & r_s_ready;
    assign w_at_last    = (r_idx == LAST_IDX);
    assign w_load_beat  = (r_state == ST_LOAD) & w_accept;
    // Framing is wrong when s_last disagrees with the final slot position.
    assign w_frame_err  = w_load_beat & (w_at_last ^ bus.s_last);
    assign w_handshake  = r_m_valid & bus.m_ready;
    assign w_timer_load = w_load_beat & w_at_last & bus.s_last;
    assign w_timer_en   = (r_state == ST_SETTLE);

    bnn_settle_timer #(
        .CNT_W(CNT_W)
    ) u_settle_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_timer_load),
        .i_load_val (SETTLE_LOAD),
        .i_en       (w_timer_en),
        .o_done     (w_timer_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_LOAD;
            r_idx       <= '0;
            r_feat_bus  <= '0;
            r_s_ready   <= 1'b1;
            r_m_valid   <= 1'b0;
            r_m_pred    <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_frame_err;
            case (r_state)
                ST_LOAD: begin
                    if (w_accept) begin
                        for (int i = 0; i < FEAT_CNT; i++) begin
                            if (r_idx == IDX_BITS'(i)) begin
                                r_feat_bus[i*FEAT_BITS +: FEAT_BITS] <= bus.s_data;
                            end
                        end
                        if (!w_at_last) begin
                            r_idx <= bus.s_last ? '0 : r_idx + 1'b1;
                        end else begin
                            r_idx <= '0;
                            if (bus.s_last) begin
                                r_state   <= ST_SETTLE;
                                r_s_ready <= 1'b0;
                            end else begin
                                r_state   <= ST_DROP;
                            end
                        end
                    end
                end
                ST_DROP: begin
                    if (w_accept && bus.s_last) begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_SETTLE: begin
                    if (w_timer_done) begin
                        r_m_pred  <= bus.pred_in;
                        r_m_valid <= 1'b1;
                        r_state   <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (w_handshake) begin
                        r_m_valid <= 1'b0;
                        r_s_ready <= 1'b1;
                        r_state   <= ST_LOAD;
                    end
                end
                default: begin
                    r_state <= ST_LOAD;
                end
            endcase
        end
    end

    assign bus.s_ready   = r_s_ready;
    assign bus.feat_bus  = r_feat_bus;
    assign bus.m_valid   = r_m_valid;
    assign bus.m_pred    = r_m_pred;
    assign bus.frame_err = r_frame_err;

`ifdef BNN_STREAMER_STATS_EN
    logic [31:0] r_sample_cnt;
    logic [15:0] r_err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sample_cnt <= '0;
            r_err_cnt    <= '0;
        end else begin
            if (w_handshake) begin
                r_sample_cnt <= r_sample_cnt + 32'd1;
            end
            if (w_frame_err) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign bus.sample_cnt = r_sample_cnt;
    assign bus.err_cnt    = r_err_cnt;
`endif

endmodule
